// File: rtl/lane_fill_pkg.sv
// rtl/lane_fill_pkg.sv - shared command and state types for lane_fill
package lane_fill_pkg;

  typedef enum logic [1:0] {
    BROADCAST = 2'd0,
    SWEEP     = 2'd1,
    CLEAR     = 2'd2,
    NOP       = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    SWEEP_S = 1'b1
  } state_t;

endpackage

// File: rtl/lane_fill_bank_if.sv
// rtl/lane_fill_bank_if.sv - LaneBank interface holding the lane storage array
interface LaneBank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0] x [DEPTH];
endinterface

// File: rtl/lane_fill_ctrl.sv
// rtl/lane_fill_ctrl.sv - command FSM producing per-lane write strobes and write value
module lane_fill_ctrl
  import lane_fill_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [DEPTH-1:0] wr_en_o,
  output logic [WIDTH-1:0] wr_data_o
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    done_d    = 1'b0;
    wr_en_o   = '0;
    wr_data_o = '0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          case (mode_t'(mode_i))
            BROADCAST: begin
              wr_en_o   = '1;
              wr_data_o = data_i;
              done_d    = 1'b1;
            end
            CLEAR: begin
              wr_en_o = '1;
              done_d  = 1'b1;
            end
            SWEEP: begin
              wr_en_o[0] = 1'b1;
              wr_data_o  = data_i;
              if (DEPTH == 1) begin
                done_d = 1'b1;
              end else begin
                base_d  = data_i;
                cnt_d   = CW'(1);
                state_d = SWEEP_S;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      SWEEP_S: begin
        // Lane index and increment share cnt; the sum wraps at WIDTH bits.
        for (int k = 0; k < DEPTH; k++) wr_en_o[k] = (cnt_q == CW'(k));
        wr_data_o = base_q + WIDTH'(cnt_q);
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == SWEEP_S);
  assign done_o  = done_q;

endmodule

// File: rtl/lane_fill.sv
// rtl/lane_fill.sv - multi-mode lane bank fill; LANE_FILL_PARITY_EN adds per-lane parity output o_par
module lane_fill
  import lane_fill_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
`ifdef LANE_FILL_PARITY_EN
  output logic             o_par  [DEPTH],
`endif
  output logic [WIDTH-1:0] o_lane [DEPTH]
);

  LaneBank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank ();

  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;

  lane_fill_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ctrl (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .valid_i   (i_valid),
    .mode_i    (i_mode),
    .data_i    (i_data),
    .ready_o   (o_ready),
    .busy_o    (o_busy),
    .done_o    (o_done),
    .wr_en_o   (wr_en),
    .wr_data_o (wr_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      foreach (u_bank.x[k]) u_bank.x[k] <= '0;
    end else begin
      foreach (u_bank.x[k]) if (wr_en[k]) u_bank.x[k] <= wr_data;
    end
  end

  assign o_lane = u_bank.x;

`ifdef LANE_FILL_PARITY_EN
  logic par_q [DEPTH];

  // Parity tracks the lane write on the same edge so it never lags o_lane.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      foreach (par_q[k]) par_q[k] <= 1'b0;
    end else begin
      foreach (par_q[k]) if (wr_en[k]) par_q[k] <= ^wr_data;
    end
  end

  assign o_par = par_q;
`endif

endmodule
